// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES group scheduler.
// Holds the FSM state encoding, the default group length and counter width,
// and two small helpers for owner selection and one-hot encoding.
package aes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int GROUP_LEN_DEF = 4;
  localparam int CNT_W_DEF     = 3;

  // Round-robin pick between two requesters: on contention the one that was
  // not served last wins; a lone requester always wins.
  function automatic logic pick_owner(input logic [1:0] req, input logic last);
    logic sel;
    if (req == 2'b11) sel = ~last;
    else              sel = ~req[0];
    return sel;
  endfunction

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/aes_grp_cnt.sv
// Completion counter for one granted group.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   clear        : zero the count (dominates inc)
//   inc          : one block completed this cycle
//   terminal     : this cycle's increment brings the count to GROUP_LEN
// The count saturates instead of wrapping, and the compare is done at CNT_W.
module aes_grp_cnt
  import aes_sched_pkg::*;
#(
  parameter int GROUP_LEN = GROUP_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam logic [CNT_W-1:0] TERM    = CNT_W'(GROUP_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_plus;

  assign cnt_plus = cnt + CNT_W'(1);

  // Terminal is evaluated on the post-increment value so the FSM can leave
  // WAIT in the same cycle as the completing strobe.
  assign terminal = inc && (cnt != CNT_MAX) && (cnt_plus == TERM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt_plus;
    end
  end

endmodule

// File: rtl/aes_group_sched.sv
// Two-requester scheduler that grants a single AES core to one requester for
// a group of GROUP_LEN blocks, one block in flight at a time.
// Ports:
//   clk, reset_n  : clock and asynchronous active-low reset
//   req[1:0]      : requester has a group pending (held until its grp_done)
//   blk_vld[1:0]  : requester presents a block
//   blk_rdy[1:0]  : block accepted this cycle (owner only, ISSUE only)
//   core_start    : one-cycle launch pulse to the core
//   core_busy     : core cannot accept a launch
//   o_strob       : core finished one block
//   grant[1:0]    : one-hot owner, zero when idle
//   grp_done      : one-cycle pulse when the owner's group completes
//   err           : sticky flag for a completion strobe outside WAIT
module aes_group_sched
  import aes_sched_pkg::*;
#(
  parameter int GROUP_LEN = GROUP_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] blk_vld,
  output logic [1:0] blk_rdy,
  output logic       core_start,
  input  logic       core_busy,
  input  logic       o_strob,
  output logic [1:0] grant,
  output logic       grp_done,
  output logic       err
);

  localparam logic [CNT_W-1:0] ISSUE_LIM = CNT_W'(GROUP_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state, state_nx;
  logic             owner, owner_nx;
  logic             last;
  logic [CNT_W-1:0] issue_cnt;
  logic             arb;
  logic             issue_fire;
  logic             cnt_inc;
  logic             cnt_term;

  // Arbitration and completion counting are kept outside the FSM block so the
  // terminal compare feeds back without a combinational loop through it.
  assign arb     = (state == IDLE) && (req != 2'b00);
  assign cnt_inc = (state == WAIT) && o_strob;

  aes_grp_cnt #(
    .GROUP_LEN (GROUP_LEN),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (arb),
    .inc      (cnt_inc),
    .terminal (cnt_term)
  );

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    blk_rdy    = 2'b00;
    core_start = 1'b0;
    grp_done   = 1'b0;
    issue_fire = 1'b0;
    case (state)
      IDLE: begin
        if (arb) begin
          owner_nx = pick_owner(req, last);
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        // The issue limit guards the one-in-flight rule should a strobe
        // sequence ever go astray; in normal operation it is always open.
        if (blk_vld[owner] && !core_busy && (issue_cnt < ISSUE_LIM)) begin
          blk_rdy    = owner_onehot(owner);
          core_start = 1'b1;
          issue_fire = 1'b1;
          state_nx   = WAIT;
        end
      end
      WAIT: begin
        if (o_strob) state_nx = cnt_term ? DONE : ISSUE;
      end
      DONE: begin
        grp_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      grant     <= 2'b00;
      issue_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      if (arb) begin
        grant     <= owner_onehot(owner_nx);
        issue_cnt <= '0;
      end else if (issue_fire && (issue_cnt != CNT_MAX)) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (state == DONE) begin
        grant <= 2'b00;
        last  <= owner;
      end
      if (o_strob && (state != WAIT)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_group_sched.sv
// Directed bench for aes_group_sched: a default-length instance driven by a
// fixed-latency core model, and a GROUP_LEN=1 instance driven by hand.
module tb_aes_group_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req, blk_vld, blk_rdy, grant;
  logic       core_start, core_busy, o_strob, grp_done, err;

  logic [1:0] req1, vld1, rdy1, grant1;
  logic       start1, busy1, strobe1, done1, err1;

  aes_group_sched dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .blk_vld    (blk_vld),
    .blk_rdy    (blk_rdy),
    .core_start (core_start),
    .core_busy  (core_busy),
    .o_strob    (o_strob),
    .grant      (grant),
    .grp_done   (grp_done),
    .err        (err)
  );

  aes_group_sched #(.GROUP_LEN(1), .CNT_W(3)) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req1),
    .blk_vld    (vld1),
    .blk_rdy    (rdy1),
    .core_start (start1),
    .core_busy  (busy1),
    .o_strob    (strobe1),
    .grant      (grant1),
    .grp_done   (done1),
    .err        (err1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int n_start = 0, n_done = 0, n_both = 0, n_strobe = 0, n1_start = 0;
  int cyc = 0, grant_cyc = 0, done_cyc = 0;
  int cd = 0;
  int core_lat = 3;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] grant_log[$];

  logic [1:0] s_grant, s_rdy, s1_grant;
  logic       s_start, s_done, s_err, s1_start, s1_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample outputs at the falling edge, then drive the
  // next cycle's core strobe just after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_grant  = grant;  s_rdy  = blk_rdy; s_start = core_start;
    s_done   = grp_done; s_err = err;
    s1_grant = grant1; s1_start = start1; s1_done = done1;
    if (core_start) n_start++;
    if (grp_done) begin n_done++; done_cyc = cyc; end
    if (grant == 2'b11) n_both++;
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      grant_log.push_back(grant);
      grant_cyc = cyc;
    end
    prev_grant = grant;
    if (o_strob) n_strobe++;
    if (start1) n1_start++;
    if (core_start) cd = core_lat;
    @(posedge clk);
    #1;
    cyc++;
    o_strob = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) o_strob = 1'b1;
    end
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int d0;
    int k;
    d0 = n_done;
    k = 0;
    while (n_done == d0 && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, 32'(n_done != d0), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cd = 0;
    o_strob = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, d0, g0;
    reset_n = 1'b0;
    req = 2'b00; blk_vld = 2'b00; core_busy = 1'b0; o_strob = 1'b0;
    req1 = 2'b00; vld1 = 2'b00; busy1 = 1'b0; strobe1 = 1'b0;
    #1;

    // Reset state
    do_reset();
    chk("rst_grant", 32'(s_grant), 32'h0);
    chk("rst_done",  32'(s_done),  32'h0);
    chk("rst_err",   32'(s_err),   32'h0);
    chk("rst_rdy",   32'(s_rdy),   32'h0);
    chk("rst_start", 32'(s_start), 32'h0);

    // Single requester, core answers 3 cycles after each launch
    s0 = n_start; d0 = n_done; g0 = grant_log.size();
    req = 2'b01; blk_vld = 2'b01;
    run_until_done("single", 60);
    req = 2'b00;
    tick(); tick();
    chk("single_starts",  32'(n_start - s0), 32'd4);
    chk("single_dones",   32'(n_done - d0),  32'd1);
    chk("single_grant",   32'(grant_log[g0]), 32'h1);
    chk("single_latency", 32'(done_cyc - grant_cyc), 32'd16);
    chk("single_idle_grant", 32'(s_grant), 32'h0);
    chk("single_err",     32'(s_err), 32'h0);

    // Contention over two groups after a fresh reset
    do_reset();
    s0 = n_start; d0 = n_done; g0 = grant_log.size();
    req = 2'b11; blk_vld = 2'b11;
    run_until_done("cont1", 60);
    run_until_done("cont2", 60);
    req = 2'b00;
    tick(); tick();
    chk("cont_starts", 32'(n_start - s0), 32'd8);
    chk("cont_dones",  32'(n_done - d0),  32'd2);
    chk("cont_grant1", 32'(grant_log[g0]),   32'h1);
    chk("cont_grant2", 32'(grant_log[g0+1]), 32'h2);
    chk("cont_idle",   32'(s_grant), 32'h0);

    // Backpressure: busy for five ISSUE cycles, transfer on the first free one
    s0 = n_start;
    req = 2'b01; blk_vld = 2'b01; core_busy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_start_held", 32'(s_start), 32'h0);
      chk("bp_rdy_held",   32'(s_rdy),   32'h0);
    end
    chk("bp_grant", 32'(s_grant), 32'h1);
    core_busy = 1'b0;
    tick();
    chk("bp_start", 32'(s_start), 32'h1);
    chk("bp_rdy",   32'(s_rdy),   32'h1);
    run_until_done("bp", 60);
    req = 2'b00;
    tick();
    chk("bp_starts", 32'(n_start - s0), 32'd4);

    // Spurious strobe while idle
    tick();
    o_strob = 1'b1;
    tick();
    tick();
    chk("spur_err", 32'(s_err), 32'h1);
    for (int i = 0; i < 3; i++) tick();
    chk("spur_err_hold", 32'(s_err), 32'h1);
    s0 = n_start; d0 = n_done; g0 = grant_log.size();
    req = 2'b10; blk_vld = 2'b10;
    run_until_done("spur_grp", 60);
    req = 2'b00;
    tick();
    chk("spur_starts", 32'(n_start - s0), 32'd4);
    chk("spur_grant",  32'(grant_log[g0]), 32'h2);
    chk("spur_err_after", 32'(s_err), 32'h1);

    // Reset after two completions abandons the group
    do_reset();
    s0 = n_strobe;
    req = 2'b01; blk_vld = 2'b01;
    for (int k = 0; k < 40 && (n_strobe - s0) < 2; k++) tick();
    chk("mid_two_strobes", 32'(n_strobe - s0), 32'd2);
    #2;
    reset_n = 1'b0;
    cd = 0;
    o_strob = 1'b0;
    req = 2'b00;
    #1;
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_done",  32'(grp_done), 32'h0);
    chk("mid_rst_start", 32'(core_start), 32'h0);
    d0 = n_done;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("mid_no_done", 32'(n_done - d0), 32'd0);
    chk("mid_err", 32'(s_err), 32'h0);
    s0 = n_start; g0 = grant_log.size();
    req = 2'b10; blk_vld = 2'b10;
    run_until_done("mid_new", 60);
    req = 2'b00;
    tick();
    chk("mid_new_starts", 32'(n_start - s0), 32'd4);
    chk("mid_new_grant",  32'(grant_log[g0]), 32'h2);
    chk("mid_new_dones",  32'(n_done - d0), 32'd1);

    // GROUP_LEN=1 instance
    req1 = 2'b01; vld1 = 2'b01;
    tick();
    chk("gl1_idle_grant", 32'(s1_grant), 32'h0);
    tick();
    chk("gl1_start", 32'(s1_start), 32'h1);
    chk("gl1_grant", 32'(s1_grant), 32'h1);
    strobe1 = 1'b1;
    tick();
    strobe1 = 1'b0;
    chk("gl1_no_early_done", 32'(s1_done), 32'h0);
    tick();
    chk("gl1_done", 32'(s1_done), 32'h1);
    req1 = 2'b00;
    tick();
    chk("gl1_done_pulse", 32'(s1_done), 32'h0);
    chk("gl1_grant_drop", 32'(s1_grant), 32'h0);
    chk("gl1_starts", 32'(n1_start), 32'd1);
    chk("gl1_err", 32'(err1), 32'h0);

    chk("never_both_granted", 32'(n_both), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
